// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 round sequencer owning the cipher state and round counter.
// Drives one combinational round datapath per cycle and fetches round keys by index.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic [127:0] rd_state,
    output logic         rd_last,
    input  logic [127:0] rd_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round
);
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm, fsm_nxt;
    logic [127:0] st, st_nxt;
    logic [3:0]   rnd, rnd_nxt;
    logic         at_last;

    assign at_last = rnd == LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fsm <= IDLE;
            st  <= '0;
            rnd <= '0;
        end else begin
            fsm <= fsm_nxt;
            st  <= st_nxt;
            rnd <= rnd_nxt;
        end

    // In IDLE the key store is addressed at 0, so rk_data is the whitening key.
    always_comb begin
        fsm_nxt = fsm;
        st_nxt  = st;
        rnd_nxt = rnd;
        case (fsm)
            IDLE: if (in_valid) begin
                fsm_nxt = ROUND;
                st_nxt  = in_data ^ rk_data;
                rnd_nxt = 4'd1;
            end
            ROUND: begin
                st_nxt  = rd_result;
                fsm_nxt = at_last ? DONE : ROUND;
                rnd_nxt = at_last ? rnd : rnd + 4'd1;
            end
            DONE: if (out_ready) begin
                fsm_nxt = IDLE;
                rnd_nxt = '0;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = fsm == IDLE;
        out_valid = fsm == DONE;
        busy      = fsm != IDLE;
        rk_addr   = fsm == ROUND ? rnd : 4'd0;
        rd_last   = fsm == ROUND && at_last;
        rd_state  = st;
        out_data  = st;
        round     = rnd;
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives the controller with a real AES round datapath and key store,
// and checks every cycle against a block-level AES model (cycles since acceptance).
module tb_aes_round_ctrl;
    localparam int NR = 10;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0, key = K1;
    logic [127:0] rk_data, rd_state, rd_result, out_data;
    logic [3:0] rk_addr, round;
    logic in_ready, rd_last, out_valid, busy;
    logic [15:0][127:0] rks;

    int pass_cnt = 0, total_cnt = 0, cyc_n = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_addr(rk_addr), .rk_data(rk_data), .rd_state(rd_state), .rd_last(rd_last),
        .rd_result(rd_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .round(round)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, base, e, s;
        inv = 8'h01;
        base = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        s = 8'h63 ^ inv;
        for (int k = 1; k < 5; k++) s ^= 8'((inv << k) | (inv >> (8 - k)));
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [7:0] m0, m1, m2, m3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = sbox(a[r+4*((c+r)%4)]);
        if (!last)
            for (int c = 0; c < 4; c++) begin
                m0 = t[4*c]; m1 = t[4*c+1]; m2 = t[4*c+2]; m3 = t[4*c+3];
                t[4*c]   = gmul(m0, 8'd2) ^ gmul(m1, 8'd3) ^ m2 ^ m3;
                t[4*c+1] = m0 ^ gmul(m1, 8'd2) ^ gmul(m2, 8'd3) ^ m3;
                t[4*c+2] = m0 ^ m1 ^ gmul(m2, 8'd2) ^ gmul(m3, 8'd3);
                t[4*c+3] = gmul(m0, 8'd3) ^ m1 ^ m2 ^ gmul(m3, 8'd2);
            end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [15:0][127:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        logic [15:0][127:0] ks;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'd2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // State after whitening plus n rounds; n == NR is the ciphertext.
    function automatic logic [127:0] aes_rounds(input logic [127:0] pt, input logic [127:0] k, input int n);
        logic [15:0][127:0] ks;
        logic [127:0] s;
        ks = expand(k);
        s = pt ^ ks[0];
        for (int r = 1; r <= n; r++) s = aes_round(s, ks[r], r == NR);
        return s;
    endfunction

    assign rks = expand(key);
    assign rk_data = rks[rk_addr];
    assign rd_result = aes_round(rd_state, rk_data, rd_last);

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Block-level model: -1 idle, 1..NR round cycles, NR+1 done.
    int cnt = -1;
    logic fresh = 1'b1;
    logic [127:0] pt_m = '0, key_m = '0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= -1;
            fresh <= 1'b1;
        end else if (cnt < 0) begin
            if (in_valid) begin
                cnt <= 1;
                pt_m <= in_data;
                key_m <= key;
                fresh <= 1'b0;
            end
        end else if (cnt <= NR) cnt <= cnt + 1;
        else if (out_ready) cnt <= -1;

    always @(negedge clk) begin
        cyc_n++;
        if (rst_n) begin
            if (in_valid && in_ready) acc_q.push_back(cyc_n);
            chk("in_ready", 128'(in_ready), 128'(cnt < 0));
            chk("busy", 128'(busy), 128'(cnt >= 0));
            chk("out_valid", 128'(out_valid), 128'(cnt == NR + 1));
            chk("rk_addr", 128'(rk_addr), 128'((cnt >= 1 && cnt <= NR) ? cnt : 0));
            chk("rd_last", 128'(rd_last), 128'(cnt == NR));
            chk("round", 128'(round), 128'(cnt < 0 ? 0 : cnt > NR ? NR : cnt));
            if (cnt >= 1 && cnt <= NR) chk("rd_state", rd_state, aes_rounds(pt_m, key_m, cnt - 1));
            if (cnt == NR + 1) chk("out_data", out_data, aes_rounds(pt_m, key_m, NR));
            if (cnt < 0 && fresh) chk("out_data_reset", out_data, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 50) begin step(); n++; end
        chk("send_timeout", 128'(n < 50), 128'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic finish_block(input bit rnd);
        int n = 0;
        while (busy && n < 80) begin
            out_ready = rnd ? 1'($urandom) : 1'b1;
            step();
            n++;
        end
        out_ready = 1'b0;
        chk("complete_timeout", 128'(n < 80), 128'(1));
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!out_valid && c < 40) begin step(); c++; end
    endtask

    initial begin
        int c, n, base;
        logic [127:0] d, hold;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_round", 128'(round), 128'(0));
        chk("model_fips_b", aes_rounds(P2, K2, NR), C2);
        chk("model_fips_c", aes_rounds(P1, K1, NR), C1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // FIPS-197 C.1 vector, sequencing trace and backpressure
        key = K1;
        send(P1);
        for (c = 1; !out_valid && c < 40; c++) begin
            chk("seq_rk_addr", 128'(rk_addr), 128'(c));
            chk("seq_rd_last", 128'(rd_last), 128'(c == 10));
            chk("seq_busy", 128'(busy), 128'(1));
            step();
        end
        chk("latency", 128'(c), 128'(11));
        chk("fips_c1", out_data, C1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_data", out_data, C1);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_busy", 128'(busy), 128'(0));

        // FIPS-197 B vector
        key = K2;
        send(P2);
        wait_done(c);
        chk("fips_b", out_data, C2);
        finish_block(1'b0);

        // Back-to-back with in_valid and out_ready held high
        key = K1;
        base = acc_q.size();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = P1;
        n = 0;
        while (acc_q.size() < base + 1 && n < 50) begin step(); n++; end
        in_data = P2;
        while (acc_q.size() < base + 2 && n < 80) begin step(); n++; end
        in_valid = 1'b0;
        chk("b2b_timeout", 128'(n < 80), 128'(1));
        if (acc_q.size() >= base + 2) chk("b2b_spacing", 128'(acc_q[base+1] - acc_q[base]), 128'(12));
        finish_block(1'b0);

        // in_valid and out_ready pulsed during ROUND must be ignored
        key = {$urandom, $urandom, $urandom, $urandom};
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d);
        step();
        step();
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = ~d;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_done(c);
        chk("ignored_result", out_data, aes_rounds(d, key, NR));
        finish_block(1'b0);

        // Random blocks, random keys, gaps and backpressure
        for (int b = 0; b < 20; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
            send({$urandom, $urandom, $urandom, $urandom});
            finish_block(1'b1);
        end

        // Asynchronous reset in the middle of round 5
        key = K2;
        send(P2);
        n = 0;
        while (round != 4'd5 && n < 40) begin step(); n++; end
        chk("reach_round5", 128'(round), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        hold = out_data;
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_rk_addr", 128'(rk_addr), 128'(0));
        chk("mid_rst_rd_last", 128'(rd_last), 128'(0));
        chk("mid_rst_round", 128'(round), 128'(0));
        chk("mid_rst_out_data", hold, '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        key = K1;
        send(P1);
        wait_done(c);
        chk("post_rst_latency", 128'(c), 128'(11));
        chk("post_rst_fips", out_data, C1);
        finish_block(1'b0);

        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
